// File: rtl/sub128_serial_pkg.sv
// Shared constants and FSM encoding for the serial slice-wise subtractor.
//   WIDTH_DEF   : default operand width
//   SLICE_W_DEF : default bits processed per cycle
//   NSLICES     : slices per operation
//   IDX_W       : width of the slice index
package sub128_serial_pkg;

    localparam int unsigned WIDTH_DEF   = 128;
    localparam int unsigned SLICE_W_DEF = 8;
    localparam int unsigned NSLICES     = WIDTH_DEF / SLICE_W_DEF;
    localparam int unsigned IDX_W       = $clog2(NSLICES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sub128_serial_slice.sv
// One slice of the subtractor: d = x - y - borrow_in over SLICE_W+1 bits.
//   x, y       : slice operands
//   borrow_in  : borrow from the previous (lower) slice
//   d          : low SLICE_W bits of the difference
//   borrow_out : top bit of the extended difference, set when the slice underflows
module sub_slice_9bit
    import sub128_serial_pkg::*;
#(
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               borrow_in,
    output logic [SLICE_W-1:0] d,
    output logic               borrow_out
);

    logic [SLICE_W:0] ext_c;

    // Zero-extended subtraction; an underflow wraps and sets the top bit.
    assign ext_c      = {1'b0, x} - {1'b0, y} - {{SLICE_W{1'b0}}, borrow_in};
    assign d          = ext_c[SLICE_W-1:0];
    assign borrow_out = ext_c[SLICE_W];

endmodule

// File: rtl/sub128_serial.sv
// Serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, borrow = (a < b),
// computed SLICE_W bits per cycle, LSB slice first, through a single slice unit.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b                 : minuend, subtrahend
//   out_valid / out_ready: result handshake (valid only in DONE)
//   diff, borrow         : result, held until the next result overwrites it
module sub128_serial
    import sub128_serial_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned NS = WIDTH / SLICE_W;
    localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

    state_e                        state_q, state_d;
    logic [NS-1:0][SLICE_W-1:0]    a_q, a_d;
    logic [NS-1:0][SLICE_W-1:0]    b_q, b_d;
    logic [NS-1:0][SLICE_W-1:0]    diff_q, diff_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic                          bint_q, bint_d;
    logic                          borrow_q, borrow_d;
    logic                          in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d;

    logic [SLICE_W-1:0]            slice_d_c;
    logic                          slice_bout_c;

    // Single slice unit, time-multiplexed by the slice index.
    sub_slice_9bit #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .x          (a_q[idx_q]),
        .y          (b_q[idx_q]),
        .borrow_in  (bint_q),
        .d          (slice_d_c),
        .borrow_out (slice_bout_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            bint_q      <= 1'b0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            idx_q       <= idx_d;
            bint_q      <= bint_d;
            borrow_q    <= borrow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        bint_d   = bint_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    bint_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d[idx_q] = slice_d_c;
                bint_d        = slice_bout_c;
                idx_d         = idx_q + IW'(1);
                if (idx_q == IW'(NS - 1)) begin
                    borrow_d = slice_bout_c;
                    idx_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_sub128_serial.sv
// Self-checking bench for sub128_serial: directed cases plus a random stream,
// with expected results queued at acceptance and compared at the result handshake.
module tb_sub128_serial;
    import sub128_serial_pkg::*;

    localparam int unsigned W  = WIDTH_DEF;
    localparam int unsigned NS = NSLICES;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    sub128_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_w();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.bo = (x < y);
        return e;
    endfunction

    // Offer one operand pair for one edge; queue its expected result if accepted.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output bit rdy);
        @(negedge clk);
        rdy      = in_ready;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        if (in_ready) sb.push_back(model(x, y));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count negedges until out_valid, bounded.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic take(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (diff !== '0) $display("FAIL reset_diff: got %h want 0", diff); else passed++;
        checks++; if (borrow !== 1'b0) $display("FAIL reset_borrow: got %b want 0", borrow); else passed++;
    endtask

    task automatic test_basic();
        bit   rdy;
        int   n;
        exp_t e;
        send(W'(5), W'(3), rdy);
        checks++; if (rdy !== 1'b1) $display("FAIL basic_accept: in_ready got %b want 1", rdy); else passed++;
        wait_out(n);
        checks++; if (n != NS) $display("FAIL basic_latency: got %0d want %0d", n, NS); else passed++;
        take(e);
        checks++; if (diff !== W'(2)) $display("FAIL basic_diff: got %h want %h", diff, W'(2)); else passed++;
        checks++; if (diff !== e.d) $display("FAIL basic_model: got %h want %h", diff, e.d); else passed++;
        checks++; if (borrow !== 1'b0) $display("FAIL basic_borrow: got %b want 0", borrow); else passed++;
        handshake();
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_idle: in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_wrap();
        logic [W-1:0] xs[5];
        logic [W-1:0] ys[5];
        bit   rdy;
        int   n;
        exp_t e;
        xs[0] = '0;                          ys[0] = W'(1);
        xs[1] = rand_w();                    ys[1] = xs[1];
        xs[2] = W'(128'h1_0000_0000_0000_0000); ys[2] = W'(1);
        xs[3] = '1;                          ys[3] = '1;
        xs[4] = W'(128'h100);                ys[4] = W'(128'h101);
        for (int i = 0; i < 5; i++) begin
            send(xs[i], ys[i], rdy);
            wait_out(n);
            checks++; if (out_valid !== 1'b1) $display("FAIL wrap%0d_timeout: out_valid got %b want 1", i, out_valid); else passed++;
            take(e);
            checks++; if (diff !== e.d) $display("FAIL wrap%0d_diff: got %h want %h", i, diff, e.d); else passed++;
            checks++; if (borrow !== e.bo) $display("FAIL wrap%0d_borrow: got %b want %b", i, borrow, e.bo); else passed++;
            handshake();
        end
    endtask

    task automatic test_stall();
        bit   rdy;
        int   n;
        exp_t e;
        send(rand_w(), rand_w(), rdy);
        n = 0;
        // Garbage on the operand and result handshakes while running.
        while (!out_valid && n < 64) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = rand_w();
            b         = rand_w();
            out_ready = (n < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (n != NS) $display("FAIL stall_latency: got %0d want %0d", n, NS); else passed++;
        take(e);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid%0d: got %b want 1", i, out_valid); else passed++;
            checks++; if ({diff, borrow} !== {e.d, e.bo}) $display("FAIL stall_hold%0d: got %h/%b want %h/%b", i, diff, borrow, e.d, e.bo); else passed++;
            @(negedge clk);
        end
        handshake();
        checks++; if (in_ready !== 1'b1) $display("FAIL stall_idle_ready: got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL stall_idle_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_midop();
        bit   rdy;
        int   n;
        exp_t e;
        send(rand_w(), rand_w(), rdy);
        repeat (NS / 2 - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL midrst_flags: got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
        checks++; if ({diff, borrow} !== '0) $display("FAIL midrst_outputs: got %h/%b want 0/0", diff, borrow); else passed++;
        send(W'(10), W'(20), rdy);
        wait_out(n);
        checks++; if (n != NS) $display("FAIL midrst_latency: got %0d want %0d", n, NS); else passed++;
        take(e);
        checks++; if (diff !== ~W'(9)) $display("FAIL midrst_diff: got %h want %h", diff, ~W'(9)); else passed++;
        checks++; if (borrow !== 1'b1) $display("FAIL midrst_borrow: got %b want 1", borrow); else passed++;
        handshake();
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        int   last_acc = 0;
        exp_t e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        while (got < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                take(e);
                checks++; if ({diff, borrow} !== {e.d, e.bo}) $display("FAIL b2b_result%0d: got %h/%b want %h/%b", got, diff, borrow, e.d, e.bo); else passed++;
                got++;
            end
            if (in_ready && sent < 1000) begin
                case ($urandom_range(0, 3))
                    0: begin x = rand_w(); y = x; end
                    1: begin x = W'($urandom()); y = W'($urandom()); end
                    default: begin x = rand_w(); y = rand_w(); end
                endcase
                a = x; b = y; in_valid = 1'b1;
                sb.push_back(model(x, y));
                if (sent > 0) begin
                    checks++; if (cyc - last_acc < int'(NS + 2)) $display("FAIL b2b_interval%0d: got %0d want >= %0d", sent, cyc - last_acc, NS + 2); else passed++;
                end
                last_acc = cyc;
                sent++;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                a = rand_w();
                b = rand_w();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (got != 1000) $display("FAIL b2b_count: got %0d want 1000", got); else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
